sensor_packetizer: RTL and testbench
====================================

# sensor_packetizer

Parametrised successor to the Week 2 register byte-mux. Periodically snapshots `NUM_CH` sensor channel registers of `CH_W` bits each. Serialises the snapshot into a framed byte stream: sync, sequence, channel data, checksum. Sits between the sensor register bank and the UART transmitter, and paces output with a valid/ready handshake instead of a free-running mux.

## Interface
Parameters:
- `NUM_CH`, 4, number of channels (1–16)
- `CH_W`, 8, bits per channel; multiple of 8, 8–32
- `PERIOD`, 500000, clocks between frame triggers (≥ 2)
- `SYNC_BYTE`, 8'hA5, first byte of every frame

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `ch_data`  in  NUM_CH*CH_W  packed channels; ch0 in LSBs
- `enable`  in  1  allows period timer to run
- `out_byte`  out  8  current stream byte
- `out_valid`  out  1  out_byte valid
- `out_ready`  in  1  downstream (UART TX) accepts byte
- `busy`  out  1  frame in progress (state ≠ IDLE)
- `overrun_cnt`  out  8  dropped-trigger count, saturating

## Operation
- Period timer: counts 0..PERIOD-1 while `enable`=1; `tick` at count PERIOD-1, then wraps to 0. `enable`=0 clears the count to 0 and suppresses `tick`. A frame already in progress still completes.
- On `tick` with state=IDLE: all of `ch_data` is captured into a snapshot register in one cycle, and the state goes to SYNC. Later changes on `ch_data` do not affect the frame.
- On `tick` with state≠IDLE: the trigger is dropped and `overrun_cnt` increments, saturating at 255. This is evaluated against the registered state, so a tick in the same cycle as CHK acceptance is also dropped.
- State sequence and byte presented in each state:
  - IDLE: no byte.
  - SYNC: `SYNC_BYTE`.
  - SEQ: 8-bit frame sequence number.
  - DATA: ch0..ch(NUM_CH-1), each channel MSB byte first; BPC = CH_W/8 bytes per channel.
  - CHK: checksum.
- State transitions: SYNC→SEQ→DATA (NUM_CH×BPC bytes)→CHK→IDLE. Each transition occurs only on acceptance (`out_valid` & `out_ready`).
- Frame length is 3 + NUM_CH×BPC bytes.
- Checksum: 8-bit sum modulo 256 of the SEQ byte and all DATA bytes. SYNC is excluded.
- The sequence number increments modulo 256 on CHK acceptance.
- Handshake: `out_byte` is stable and `out_valid` stays high until accepted, with no retraction. `out_ready` may toggle freely.
- Reset values: `out_byte`=0, `out_valid`=0, `busy`=0, `overrun_cnt`=0, sequence=0, timer=0, state=IDLE, snapshot=0.
- Reset mid-frame aborts the frame. The first frame after reset carries SEQ=00.

## Timing
- `tick` to `out_valid`=1 with SYNC: 1 cycle (registered).
- Acceptance to next byte valid: next cycle. With `out_ready` held high, the block sustains 1 byte/clk and a frame occupies exactly frame-length cycles.
- After CHK acceptance, `out_valid`=0 and `busy`=0 on the following cycle. The earliest next frame starts on the next `tick`.
- No drops with `out_ready`=1 requires PERIOD ≥ frame length + 1.
- `rst_n` assertion clears all outputs immediately (asynchronous). Release is synchronised externally.

## Structure
- Package `sensor_pkt_pkg`:
  - state enum (IDLE, SYNC, SEQ, DATA, CHK)
  - default `SYNC_BYTE` constant
  - function for frame length from NUM_CH/CH_W
- Sub-module `period_timer`: parametrised by PERIOD; inputs clk, rst_n, enable; output 1-cycle `tick`.
- Data path: snapshot register, byte index counter of width $clog2(NUM_CH×BPC), 8-bit running checksum accumulated on each accepted SEQ/DATA byte.

## Test plan
- NUM_CH=4, CH_W=8, PERIOD=16, ready=1, ch_data={44,33,22,11}: stream A5 00 11 22 33 44 AA. The next frame is A5 01 11 22 33 44 AB, 16 cycles later.
- NUM_CH=2, CH_W=16, ch0=1234, ch1=ABCD: stream A5 00 12 34 AB CD BE.
- Backpressure: drop `out_ready` for 5 cycles while byte 22 is presented. `out_byte`=22 and `out_valid`=1 must hold all 5 cycles; the stream then resumes with 33 and no byte is lost or duplicated.
- Snapshot: change ch_data to {00,00,00,00} one cycle after tick. The frame still carries 11 22 33 44 with checksum AA.
- Overrun: `out_ready`=0, PERIOD=4, run 3 more ticks after the frame starts. `overrun_cnt`=3 and SYNC stays presented. Forcing 300 drops leaves `overrun_cnt`=255.
- Reset mid-DATA: `rst_n`=0 asynchronously drives `out_valid`=0 and `busy`=0 within the same cycle. After release, the first frame has SEQ=00 and `overrun_cnt`=0.

Source files
------------

// File: rtl/sensor_pkt_pkg.sv
// Shared definitions for the sensor packetizer.
// State encoding, default sync byte and frame length helper.
package sensor_pkt_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_SYNC = 3'd1;
  localparam state_t ST_SEQ  = 3'd2;
  localparam state_t ST_DATA = 3'd3;
  localparam state_t ST_CHK  = 3'd4;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

  function automatic int frame_len(
    input int num_ch,
    input int ch_w
  );
    return 3 + num_ch * (ch_w / 8);
  endfunction

endpackage

// File: rtl/period_timer.sv
// Free-running frame trigger; emits a 1-cycle tick
// every PERIOD clocks while enabled.
module period_timer #(
  parameter int PERIOD = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sensor_packetizer.sv
// Snapshots NUM_CH sensor channels and streams them as a framed
// byte sequence: sync, sequence, channel data, checksum.
module sensor_packetizer
  import sensor_pkt_pkg::*;
#(
  parameter int         NUM_CH    = 4,
  parameter int         CH_W      = 8,
  parameter int         PERIOD    = 500000,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH*CH_W-1:0] ch_data,
  input  logic                   enable,
  output logic [7:0]             out_byte,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic [7:0]             overrun_cnt
);

  localparam int BPC = CH_W / 8;
  localparam int NB  = NUM_CH * BPC;
  localparam int IW  = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);

  state_t                   state;
  logic [NUM_CH*CH_W-1:0]   snap;
  logic [IW-1:0]            idx;
  logic [7:0]               seq;
  logic [7:0]               csum;
  logic                     tick;
  logic                     acc;
  logic [7:0]               data_bytes [NB];

  period_timer #(
    .PERIOD (PERIOD)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (tick)
  );

  // Stream order: channel 0 first, most significant byte first
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      for (int b = 0; b < BPC; b++) begin
        data_bytes[c*BPC+b] = snap[c*CH_W + (BPC-1-b)*8 +: 8];
      end
    end
  end

  assign out_valid = (state != ST_IDLE);
  assign busy      = out_valid;
  assign acc       = out_valid && out_ready;

  always_comb begin
    out_byte = 8'h00;
    unique case (1'b1)
      state == ST_SYNC: out_byte = SYNC_BYTE;
      state == ST_SEQ:  out_byte = seq;
      state == ST_DATA: out_byte = data_bytes[idx];
      state == ST_CHK:  out_byte = csum;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      snap        <= '0;
      idx         <= '0;
      seq         <= 8'h00;
      csum        <= 8'h00;
      overrun_cnt <= 8'h00;
    end else begin
      if (tick) begin
        if (state == ST_IDLE) begin
          snap  <= ch_data;
          state <= ST_SYNC;
          idx   <= '0;
          csum  <= 8'h00;
        end else if (overrun_cnt != 8'hFF) begin
          overrun_cnt <= overrun_cnt + 8'd1;
        end
      end
      // acc implies a non-IDLE state, so it never races the tick start
      if (acc) begin
        unique case (1'b1)
          state == ST_SYNC: state <= ST_SEQ;
          state == ST_SEQ: begin
            csum  <= csum + out_byte;
            state <= ST_DATA;
          end
          state == ST_DATA: begin
            csum <= csum + out_byte;
            if (idx == IDX_LAST) begin
              state <= ST_CHK;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          state == ST_CHK: begin
            seq   <= seq + 8'd1;
            state <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sensor_packetizer.sv
// Scoreboard bench for sensor_packetizer with a frame-level
// reference model and a second instance for 16-bit channels.
module tb_sensor_packetizer;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int PER = 16;
  localparam int BPC = CW / 8;
  localparam int FL  = 3 + NCH * BPC;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              out_ready = 1'b0;
  logic [NCH*CW-1:0] ch_data = '0;
  logic [7:0]        out_byte;
  logic              out_valid;
  logic              busy;
  logic [7:0]        overrun_cnt;

  logic              rst2_n = 1'b0;
  logic [31:0]       ch2 = 32'hABCD_1234;
  logic              en2 = 1'b1;
  logic              rdy2 = 1'b1;
  logic [7:0]        ob2;
  logic [7:0]        oc2;
  logic              ov2;
  logic              bz2;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] q[$];
  logic [7:0] log_q[$];
  int rem = 0;
  int tc = 0;
  int seq_m = 0;
  int ovr_m = 0;

  always #5 clk = ~clk;

  sensor_packetizer #(
    .NUM_CH (NCH),
    .CH_W   (CW),
    .PERIOD (PER)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ch_data     (ch_data),
    .enable      (enable),
    .out_byte    (out_byte),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .overrun_cnt (overrun_cnt)
  );

  sensor_packetizer #(
    .NUM_CH (2),
    .CH_W   (16),
    .PERIOD (16)
  ) dut2 (
    .clk         (clk),
    .rst_n       (rst2_n),
    .ch_data     (ch2),
    .enable      (en2),
    .out_byte    (ob2),
    .out_valid   (ov2),
    .out_ready   (rdy2),
    .busy        (bz2),
    .overrun_cnt (oc2)
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [NCH*CW-1:0] d);
    int s;
    logic [7:0] v;
    s = seq_m;
    q.push_back(8'hA5);
    q.push_back(8'(seq_m));
    for (int c = 0; c < NCH; c++) begin
      for (int b = BPC - 1; b >= 0; b--) begin
        v = 8'(d >> (c*CW + b*8));
        q.push_back(v);
        s += int'(v);
      end
    end
    q.push_back(8'(s % 256));
    seq_m = (seq_m + 1) % 256;
    rem = FL;
  endtask

  // Applies the effect of the clock edge just passed, using the
  // inputs that were held across that edge
  task automatic model_update();
    bit tk;
    bit ac;
    if (!rst_n) return;
    tk = enable && (tc == PER - 1);
    ac = (rem > 0) && out_ready;
    if (tk) begin
      if (rem == 0) push_frame(ch_data);
      else if (ovr_m < 255) ovr_m++;
    end
    if (ac) rem--;
    tc = (!enable || tk) ? 0 : tc + 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
  endtask

  always @(negedge clk) begin
    check("valid", int'(out_valid), int'(rem > 0));
    check("busy", int'(busy), int'(rem > 0));
    check("overrun", int'(overrun_cnt), ovr_m);
    if (out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_byte", 1, 0);
      end else begin
        check("byte", int'(out_byte), int'(q[0]));
        if (out_ready) begin
          log_q.push_back(out_byte);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin : dut2_chk
    logic [7:0] g2 [7];
    int k;
    g2 = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
    k = 0;
    #16;
    rst2_n = 1'b1;
    for (int i = 0; i < 80 && k < 7; i++) begin
      @(negedge clk);
      if (ov2) begin
        check("dut2_byte", int'(ob2), int'(g2[k]));
        check("dut2_busy", int'(bz2), 1);
        k++;
      end
    end
    check("dut2_len", k, 7);
    check("dut2_overrun", int'(oc2), 0);
  end

  initial begin : main
    logic [7:0] g [14];
    bit found;
    g = '{8'hA5, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA,
          8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAB};

    #12;
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_byte", int'(out_byte), 0);
    check("rst_overrun", int'(overrun_cnt), 0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    enable = 1'b1;
    out_ready = 1'b1;
    ch_data = 32'h4433_2211;
    repeat (45) step();

    check("log_len", int'(log_q.size() >= 14), 1);
    for (int i = 0; i < 14 && i < log_q.size(); i++) begin
      check("golden_stream", int'(log_q[i]), int'(g[i]));
    end

    repeat (1500) begin
      step();
      out_ready = ($urandom % 4) != 0;
      if ($urandom % 3 == 0) ch_data = $urandom;
      enable = ($urandom % 50) != 0;
    end

    out_ready = 1'b0;
    enable = 1'b1;
    repeat (PER * 300) step();
    check("overrun_sat", int'(overrun_cnt), 255);

    out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (rem >= 2 && rem <= FL - 2) found = 1'b1;
    end
    check("reach_data", int'(found), 1);

    #2;
    rst_n = 1'b0;
    q.delete();
    log_q.delete();
    rem = 0;
    tc = 0;
    seq_m = 0;
    ovr_m = 0;
    #1;
    check("async_valid", int'(out_valid), 0);
    check("async_busy", int'(busy), 0);
    step();
    rst_n = 1'b1;
    repeat (40) step();
    check("post_rst_len", int'(log_q.size() >= FL), 1);
    if (log_q.size() >= 2) begin
      check("post_rst_sync", int'(log_q[0]), 8'hA5);
      check("post_rst_seq", int'(log_q[1]), 0);
    end
    check("post_rst_overrun", int'(overrun_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
